// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: lane steering, sign/zero extension, misalignment detection,
// single-cycle data memory path and a stalling req/ack device bus with timeout.
module mem_stage_lsu #(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] DEV_BASE    = 32'h40000000,
    parameter int unsigned       TIMEOUT_CYC = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic                in_read,
    input  logic                in_write,
    input  logic [1:0]          in_size,
    input  logic                in_signed,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    output logic                stall,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_rdata,
    output logic                misalign_err,
    output logic                timeout_err,
    output logic                mem_rd,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                dev_req,
    output logic                dev_we,
    output logic [ADDR_W-1:0]   dev_addr,
    output logic [DATA_W/8-1:0] dev_be,
    output logic [DATA_W-1:0]   dev_wdata,
    input  logic                dev_ack,
    input  logic [DATA_W-1:0]   dev_rdata
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 2 : $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic                dev_req_q, dev_req_d;
    logic                dev_we_q, dev_we_d;
    logic [ADDR_W-1:0]   dev_addr_q, dev_addr_d;
    logic [NB-1:0]       dev_be_q, dev_be_d;
    logic [DATA_W-1:0]   dev_wdata_q, dev_wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                timeout_q, timeout_d;

    logic                live;
    logic                is_dev;
    logic [OFF_W-1:0]    off;
    logic [OFF_W-1:0]    off_mask;
    logic                misalign;
    logic [NB-1:0]       be_base;
    logic [NB-1:0]       be;
    logic [DATA_W-1:0]   lane_wdata;

    // Shift the addressed lane down, keep 8<<size bits, extend from the top kept bit.
    function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] raw,
                                                  input logic [OFF_W-1:0]  offset,
                                                  input logic [1:0]        size,
                                                  input logic              sgn);
        int unsigned       bits;
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] mask;
        logic [DATA_W-1:0] res;
        sh   = raw >> {offset, 3'b000};
        bits = 32'd8 << size;
        if (bits >= DATA_W) mask = '1;
        else                mask = (DATA_W'(1) << bits) - DATA_W'(1);
        res = sh & mask;
        if (sgn && (bits < DATA_W) && (|(sh & mask & ~(mask >> 1)))) res = res | ~mask;
        return res;
    endfunction

    // Reset also gates the launch path so nothing fires while reset is held.
    assign live     = in_valid & (in_read | in_write) & ~reset;
    assign is_dev   = in_addr >= DEV_BASE;
    assign off      = in_addr[OFF_W-1:0];
    assign off_mask = OFF_W'((32'd1 << in_size) - 32'd1);
    assign misalign = (|(off & off_mask)) | ((in_size == 2'd3) && (DATA_W == 32));
    assign be       = be_base << off;
    assign cnt_inc  = cnt_q + CNT_W'(1);

    assign mem_addr  = in_addr;
    assign mem_be    = be;
    assign mem_wdata = lane_wdata;
    assign dev_req   = dev_req_q;
    assign dev_we    = dev_we_q;
    assign dev_addr  = dev_addr_q;
    assign dev_be    = dev_be_q;
    assign dev_wdata = dev_wdata_q;

    // Byte-enable pattern and store-data replication for the access size.
    always_comb begin
        be_base    = '0;
        lane_wdata = in_wdata;
        case (in_size)
            2'd0: begin
                be_base    = NB'(8'h01);
                lane_wdata = {NB{in_wdata[7:0]}};
            end
            2'd1: begin
                be_base    = NB'(8'h03);
                lane_wdata = {(NB / 2){in_wdata[15:0]}};
            end
            2'd2: begin
                be_base    = NB'(8'h0F);
                lane_wdata = {(NB / 4){in_wdata[31:0]}};
            end
            default: begin
                be_base    = NB'(8'hFF);
                lane_wdata = in_wdata;
            end
        endcase
    end

    // Next-state and output decode for the IDLE/WAIT/RESP access sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dev_req_d    = dev_req_q;
        dev_we_d     = dev_we_q;
        dev_addr_d   = dev_addr_q;
        dev_be_d     = dev_be_q;
        dev_wdata_d  = dev_wdata_q;
        rdata_d      = rdata_q;
        timeout_d    = timeout_q;
        stall        = 1'b0;
        out_valid    = 1'b0;
        out_rdata    = '0;
        misalign_err = 1'b0;
        timeout_err  = 1'b0;
        mem_rd       = 1'b0;
        mem_we       = 1'b0;
        case (state_q)
            StIdle: begin
                timeout_d = 1'b0;
                if (live) begin
                    if (misalign) begin
                        out_valid    = 1'b1;
                        misalign_err = 1'b1;
                    end else if (is_dev) begin
                        stall       = 1'b1;
                        dev_req_d   = 1'b1;
                        dev_we_d    = in_write;
                        dev_addr_d  = in_addr;
                        dev_be_d    = be;
                        dev_wdata_d = lane_wdata;
                        cnt_d       = '0;
                        state_d     = StWait;
                    end else begin
                        // Read+write together behaves as a store returning zero.
                        mem_rd    = in_read & ~in_write;
                        mem_we    = in_write;
                        out_valid = 1'b1;
                        if (!in_write) out_rdata = extract(mem_rdata, off, in_size, in_signed);
                    end
                end
            end
            StWait: begin
                stall = 1'b1;
                cnt_d = cnt_inc;
                if (dev_ack) begin
                    rdata_d   = dev_rdata;
                    dev_req_d = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = StResp;
                end else if ((TIMEOUT_CYC != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYC))) begin
                    rdata_d   = '0;
                    dev_req_d = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = StResp;
                end
            end
            StResp: begin
                out_valid   = 1'b1;
                timeout_err = timeout_q;
                if (!in_write) out_rdata = extract(rdata_q, off, in_size, in_signed);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, timeout counter and latched device request registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            dev_req_q   <= 1'b0;
            dev_we_q    <= 1'b0;
            dev_addr_q  <= '0;
            dev_be_q    <= '0;
            dev_wdata_q <= '0;
            rdata_q     <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dev_req_q   <= dev_req_d;
            dev_we_q    <= dev_we_d;
            dev_addr_q  <= dev_addr_d;
            dev_be_q    <= dev_be_d;
            dev_wdata_q <= dev_wdata_d;
            rdata_q     <= rdata_d;
            timeout_q   <= timeout_d;
        end
    end

endmodule
